// File: rtl/crypto_wallet2_random_byte_gen.sv
// crypto_wallet2_random_byte_gen
// Purpose: hardware random byte source for the wallet PIO in_port. A synchronized
//   entropy bit is sampled every SAMPLE_DIV cycles, Von Neumann debiased, XORed with
//   a 32-bit Galois LFSR bit and packed LSB-first into bytes held for software.
// Ports: clk/reset (async, active-high); entropy_in (async raw bit); enable (run);
//   consume (1-cycle ack of held byte); random_value[7:0] (held byte);
//   random_valid (unconsumed byte present); health_fail (sticky health flag).
// Option: define CRYPTO_WALLET2_RNG_HEALTH_TEST_EN to build the repetition-count
//   health test; otherwise health_fail is tied low.
module crypto_wallet2_random_byte_gen #(
  parameter int          SAMPLE_DIV = 16,
  parameter int          REP_LIMIT  = 32,
  parameter logic [31:0] LFSR_SEED  = 32'hACE1_2468
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       entropy_in,
  input  logic       enable,
  input  logic       consume,
  output logic [7:0] random_value,
  output logic       random_valid,
  output logic       health_fail
);

  // Right-shifting Galois form of x^32+x^22+x^2+x+1 (taps 32,22,2,1).
  localparam logic [31:0] LFSR_TAPS = 32'h8020_0003;
  localparam logic [15:0] DIV_LAST  = 16'(SAMPLE_DIV - 1);

  if (SAMPLE_DIV < 1 || SAMPLE_DIV > 65535) begin : g_bad_sample_div
    $error("SAMPLE_DIV must be in 1..65535");
  end
  if (REP_LIMIT < 2 || REP_LIMIT > 255) begin : g_bad_rep_limit
    $error("REP_LIMIT must be in 2..255");
  end
  if (LFSR_SEED == 32'h0) begin : g_bad_seed
    $error("LFSR_SEED must be non-zero");
  end

  typedef enum logic {
    ST_COLLECT = 1'b0,
    ST_STALL   = 1'b1
  } state_t;

  logic        r_sync1;
  logic        r_sync2;      // synchronized entropy bit (ent_s)
  logic [15:0] r_div_cnt;
  logic [31:0] r_lfsr;
  logic        r_phase;      // 0: next strobe is the first sample of a pair
  logic        r_first;      // first sample of the current pair
  logic [7:0]  r_acc;
  logic [2:0]  r_bitcnt;
  logic [7:0]  r_value;
  logic        r_valid;
  state_t      r_state;

  state_t      w_state_nxt;
  logic [7:0]  w_acc_nxt;
  logic [2:0]  w_bitcnt_nxt;
  logic [7:0]  w_value_nxt;
  logic        w_valid_nxt;
  logic [7:0]  w_shift;
  logic        w_strobe;
  logic        w_bit_vld;
  logic        w_bit;
  logic        w_fail;

  // Two-flop synchronizer for the free-running oscillator bit.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
    end else begin
      r_sync1 <= entropy_in;
      r_sync2 <= r_sync1;
    end
  end

  assign w_strobe = enable && (r_div_cnt == DIV_LAST);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_div_cnt <= 16'd0;
    end else if (!enable || w_strobe) begin
      r_div_cnt <= 16'd0;
    end else begin
      r_div_cnt <= r_div_cnt + 16'd1;
    end
  end

  // LFSR free-runs independent of enable so the mix bit is not predictable
  // from the enable history alone.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_lfsr <= LFSR_SEED;
    end else begin
      r_lfsr <= {1'b0, r_lfsr[31:1]} ^ (r_lfsr[0] ? LFSR_TAPS : 32'h0);
    end
  end

  // Von Neumann pairing: a differing pair yields its first sample (10 -> 1, 01 -> 0).
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_phase <= 1'b0;
      r_first <= 1'b0;
    end else if (!enable) begin
      r_phase <= 1'b0;
    end else if (w_strobe) begin
      if (!r_phase) begin
        r_first <= r_sync2;
      end
      r_phase <= ~r_phase;
    end
  end

  assign w_bit_vld = w_strobe && r_phase && (r_first != r_sync2) && !w_fail;
  assign w_bit     = r_first ^ r_lfsr[0];
  assign w_shift   = {w_bit, r_acc[7:1]};

`ifdef CRYPTO_WALLET2_RNG_HEALTH_TEST_EN
  localparam logic [7:0] REP_MAX = 8'(REP_LIMIT);

  logic [7:0] r_rep_cnt;
  logic       r_rep_last;
  logic       r_fail;
  logic [7:0] w_rep_nxt;

  // Count run length of identical strobe samples; r_rep_cnt==0 means no sample yet.
  always_comb begin
    w_rep_nxt = 8'd1;
    if (r_rep_cnt != 8'd0 && r_sync2 == r_rep_last) begin
      w_rep_nxt = (r_rep_cnt == REP_MAX) ? r_rep_cnt : r_rep_cnt + 8'd1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_rep_cnt  <= 8'd0;
      r_rep_last <= 1'b0;
      r_fail     <= 1'b0;
    end else if (w_strobe) begin
      r_rep_cnt  <= w_rep_nxt;
      r_rep_last <= r_sync2;
      if (w_rep_nxt == REP_MAX) begin
        r_fail <= 1'b1;
      end
    end
  end

  assign w_fail = r_fail;
`else
  assign w_fail = 1'b0;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state  <= ST_COLLECT;
      r_acc    <= 8'h00;
      r_bitcnt <= 3'd0;
      r_value  <= 8'h00;
      r_valid  <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_acc    <= w_acc_nxt;
      r_bitcnt <= w_bitcnt_nxt;
      r_value  <= w_value_nxt;
      r_valid  <= w_valid_nxt;
    end
  end

  always_comb begin
    w_state_nxt  = r_state;
    w_acc_nxt    = r_acc;
    w_bitcnt_nxt = r_bitcnt;
    w_value_nxt  = r_value;
    w_valid_nxt  = r_valid;
    case (r_state)
      ST_COLLECT: begin
        if (consume && r_valid) begin
          w_valid_nxt = 1'b0;
        end
        if (!enable) begin
          w_bitcnt_nxt = 3'd0;
        end else if (w_bit_vld) begin
          w_acc_nxt = w_shift;
          if (r_bitcnt == 3'd7) begin
            w_bitcnt_nxt = 3'd0;
            // A consume on this same cycle frees the holder, so the new byte
            // replaces the acknowledged one instead of stalling.
            if (!r_valid || consume) begin
              w_value_nxt = w_shift;
              w_valid_nxt = 1'b1;
            end else begin
              w_state_nxt = ST_STALL;
            end
          end else begin
            w_bitcnt_nxt = r_bitcnt + 3'd1;
          end
        end
      end
      ST_STALL: begin
        // acc holds a finished byte; new bits are dropped until it is taken.
        if (consume && !w_fail) begin
          w_value_nxt  = r_acc;
          w_valid_nxt  = 1'b1;
          w_bitcnt_nxt = 3'd0;
          w_state_nxt  = ST_COLLECT;
        end
      end
      default: begin
        w_state_nxt = ST_COLLECT;
      end
    endcase
  end

  assign random_value = w_fail ? 8'h00 : r_value;
  assign random_valid = r_valid && !w_fail;
  assign health_fail  = w_fail;

endmodule

// File: tb/tb_crypto_wallet2_random_byte_gen.sv
module tb_crypto_wallet2_random_byte_gen;

  localparam logic [31:0] SEED = 32'hACE1_2468;

  logic       clk;
  logic       reset;
  logic       entropy_in;
  logic       enable;
  logic       consume;
  logic [7:0] random_value;
  logic       random_valid;
  logic       health_fail;

  int checks;
  int errors;

  logic [31:0] m_lfsr;

  typedef struct {
    logic [15:0] pat;   // entropy samples, MSB first
    logic [7:0]  raw;   // debiased bits before LFSR mixing, pair 0 in bit 0
    string       name;
  } vec_t;

  vec_t vecs [4];

  crypto_wallet2_random_byte_gen #(
    .SAMPLE_DIV(1),
    .REP_LIMIT (32),
    .LFSR_SEED (SEED)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .entropy_in  (entropy_in),
    .enable      (enable),
    .consume     (consume),
    .random_value(random_value),
    .random_valid(random_valid),
    .health_fail (health_fail)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference LFSR: x^32+x^22+x^2+x+1, right-shifting Galois form.
  always @(posedge clk or posedge reset) begin
    if (reset) m_lfsr <= SEED;
    else       m_lfsr <= {1'b0, m_lfsr[31:1]} ^ (m_lfsr[0] ? 32'h8020_0003 : 32'h0);
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic pulse_consume();
    consume = 1'b1;
    tick(1);
    consume = 1'b0;
  endtask

  // Feeds nsamp samples so that strobe k captures pat[15-k] (2-cycle sync delay,
  // SAMPLE_DIV=1). mask collects the LFSR mix bit present on each pair's second
  // strobe. valid_pre is random_valid just before the last strobe edge.
  task automatic run_samples(input logic [15:0] pat, input int nsamp, input logic cons_last,
                             output logic [7:0] mask, output logic valid_pre);
    mask = 8'h00;
    valid_pre = 1'b0;
    for (int j = 0; j <= nsamp + 2; j++) begin
      entropy_in = (j < nsamp) ? pat[15 - j] : 1'b0;
      enable     = (j >= 2) && (j <= nsamp + 1);
      consume    = cons_last && (j == nsamp + 1);
      if (j >= 3 && (j - 2) < nsamp && ((j - 2) % 2 == 1)) mask[(j - 3) / 2] = m_lfsr[0];
      if (j == nsamp + 1) valid_pre = random_valid;
      if (j < nsamp + 2) tick(1);
    end
  endtask

  logic [7:0] mask;
  logic [7:0] exp_a;
  logic [7:0] exp_b;
  logic       vpre;

  initial begin
    checks = 0;
    errors = 0;
    vecs[0] = '{pat: 16'h5555, raw: 8'h00, name: "all01"};
    vecs[1] = '{pat: 16'hAAAA, raw: 8'hFF, name: "all10"};
    vecs[2] = '{pat: 16'h9999, raw: 8'h55, name: "alt"};
    vecs[3] = '{pat: 16'hA55A, raw: 8'hC3, name: "mix"};

    reset = 1'b1;
    entropy_in = 1'b0;
    enable = 1'b0;
    consume = 1'b0;
    tick(3);
    chk("rst_value", random_value, 8'h00);
    chk("rst_valid", random_valid, 1'b0);
    chk("rst_health", health_fail, 1'b0);
    chk("rst_lfsr", dut.r_lfsr, SEED);
    reset = 1'b0;

    // Table-driven byte generation: latency, value, hold, consume.
    for (int i = 0; i < 4; i++) begin
      run_samples(vecs[i].pat, 16, 1'b0, mask, vpre);
      exp_a = vecs[i].raw ^ mask;
      chk({vecs[i].name, "_valid_pre"}, vpre, 1'b0);
      chk({vecs[i].name, "_valid"}, random_valid, 1'b1);
      chk({vecs[i].name, "_value"}, random_value, exp_a);
      tick(3);
      chk({vecs[i].name, "_hold"}, {random_valid, random_value}, {1'b1, exp_a});
      pulse_consume();
      chk({vecs[i].name, "_cons_valid"}, random_valid, 1'b0);
      chk({vecs[i].name, "_cons_value"}, random_value, exp_a);
    end

    // Stall: second byte completes while first is still held.
    run_samples(vecs[0].pat, 16, 1'b0, mask, vpre);
    exp_a = vecs[0].raw ^ mask;
    run_samples(vecs[3].pat, 16, 1'b0, mask, vpre);
    exp_b = vecs[3].raw ^ mask;
    chk("stall_valid", random_valid, 1'b1);
    chk("stall_value", random_value, exp_a);
    pulse_consume();
    chk("stall_cons_valid", random_valid, 1'b1);
    chk("stall_cons_value", random_value, exp_b);
    pulse_consume();
    chk("stall_drain_valid", random_valid, 1'b0);

    // Consume on the same cycle as the 8th bit.
    run_samples(vecs[1].pat, 16, 1'b0, mask, vpre);
    exp_a = vecs[1].raw ^ mask;
    chk("coin_first_value", random_value, exp_a);
    run_samples(vecs[2].pat, 16, 1'b1, mask, vpre);
    exp_b = vecs[2].raw ^ mask;
    chk("coin_valid", random_valid, 1'b1);
    chk("coin_value", random_value, exp_b);
    pulse_consume();
    chk("coin_drain_valid", random_valid, 1'b0);

    // Disable after 3 bits: partial bits discarded, held byte retained.
    run_samples(vecs[0].pat, 16, 1'b0, mask, vpre);
    exp_a = vecs[0].raw ^ mask;
    run_samples(16'h9999, 6, 1'b0, mask, vpre);
    tick(4);
    chk("dis_hold", {random_valid, random_value}, {1'b1, exp_a});
    run_samples(vecs[1].pat, 16, 1'b0, mask, vpre);
    exp_b = vecs[1].raw ^ mask;
    chk("dis_stall_value", random_value, exp_a);
    pulse_consume();
    chk("dis_new_byte", {random_valid, random_value}, {1'b1, exp_b});
    pulse_consume();
    chk("dis_drain_valid", random_valid, 1'b0);

    // Reset in the middle of a byte (odd sample count leaves a half pair).
    run_samples(vecs[2].pat, 16, 1'b0, mask, vpre);
    chk("pre_rst_valid", random_valid, 1'b1);
    run_samples(16'hAAAA, 7, 1'b0, mask, vpre);
    reset = 1'b1;
    tick(1);
    chk("mid_rst_value", random_value, 8'h00);
    chk("mid_rst_valid", random_valid, 1'b0);
    chk("mid_rst_lfsr", dut.r_lfsr, SEED);
    reset = 1'b0;
    run_samples(vecs[3].pat, 16, 1'b0, mask, vpre);
    exp_a = vecs[3].raw ^ mask;
    chk("post_rst_valid_pre", vpre, 1'b0);
    chk("post_rst_byte", {random_valid, random_value}, {1'b1, exp_a});

    // Constant entropy: every pair is 11.
    reset = 1'b1;
    tick(2);
    reset = 1'b0;
    run_samples(16'hFFFF, 16, 1'b0, mask, vpre);
    chk("const16_health", health_fail, 1'b0);
    chk("const16_valid", random_valid, 1'b0);
    run_samples(16'hFFFF, 16, 1'b0, mask, vpre);
`ifdef CRYPTO_WALLET2_RNG_HEALTH_TEST_EN
    chk("const32_health", health_fail, 1'b1);
    chk("const32_out", {random_valid, random_value}, 9'h000);
    run_samples(vecs[1].pat, 16, 1'b0, mask, vpre);
    chk("fail_sticky", {health_fail, random_valid, random_value}, 10'h200);
`else
    chk("const32_health", health_fail, 1'b0);
    chk("const32_valid", random_valid, 1'b0);
    run_samples(16'hFFFF, 16, 1'b0, mask, vpre);
    chk("const48_out", {health_fail, random_valid}, 2'b00);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
